// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// a registered decode stage, sticky illegal-instruction halt and a retirement counter.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic [5:0]  Fun,
  input  logic        equal,
  input  logic        sign,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        nPC_sel,
  output logic        IorD,
  output logic        MemRd,
  output logic        MemWr,
  output logic        RegWr,
  output logic        RegDst,
  output logic        ExtOp,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic [2:0]  ALUctr,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  logic [2:0]  state_q, state_next;
  logic [5:0]  op_q, fun_q;
  logic        illegal_q;
  logic [15:0] instr_count_q;
  logic        retire;
  logic        is_rtype, is_imm, is_branch, taken;

  function automatic logic legal_instr(input logic [5:0] op, input logic [5:0] fun);
    case (op)
      OP_RTYPE: begin
        case (fun)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLL, F_SLT, F_SLTU: return 1'b1;
          default: return 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGTZ: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] op, input logic [5:0] fun);
    case (op)
      OP_RTYPE: begin
        case (fun)
          F_ADD:          return 3'd2;
          F_ADDU:         return 3'd4;
          F_SUB, F_SUBU:  return 3'd6;
          F_AND:          return 3'd0;
          F_OR:           return 3'd1;
          F_SLL:          return 3'd5;
          F_SLT:          return 3'd3;
          F_SLTU:         return 3'd7;
          default:        return 3'd0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW:     return 3'd2;
      OP_BEQ, OP_BNE, OP_BGTZ:   return 3'd6;
      default:                   return 3'd0;
    endcase
  endfunction

  assign is_rtype  = (op_q == OP_RTYPE);
  assign is_imm    = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
  assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_BGTZ);

  always_comb begin
    taken = 1'b0;
    case (op_q)
      OP_BEQ:  taken = equal;
      OP_BNE:  taken = !equal;
      OP_BGTZ: taken = !(equal | sign);
      default: taken = 1'b0;
    endcase
  end

  // Next-state logic; Op/Fun are only looked at live in DECODE.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = legal_instr(Op, Fun) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_rtype || op_q == OP_ADDI)     state_next = S_WB;
        else if (op_q == OP_LW || op_q == OP_SW) state_next = S_MEM;
        else                                  state_next = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready) state_next = (op_q == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  assign retire = (state_next == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      op_q          <= 6'd0;
      fun_q         <= 6'd0;
      illegal_q     <= 1'b0;
      instr_count_q <= 16'd0;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) begin
        op_q  <= Op;
        fun_q <= Fun;
        if (!legal_instr(Op, Fun)) illegal_q <= 1'b1;
      end
      instr_count_q <= instr_count_q + {15'd0, retire};
    end
  end

  // Strobes are forced low while reset is high so a mid-access reset drops them at once.
  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    nPC_sel  = 1'b0;
    IorD     = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    ExtOp    = 1'b0;
    ALUSrc   = 1'b0;
    MemToReg = 1'b0;
    ALUctr   = 3'd0;
    if (!reset) begin
      if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
        ALUctr = alu_code(op_q, fun_q);
        RegDst = is_rtype;
        ExtOp  = is_imm;
        ALUSrc = is_imm;
      end
      case (state_q)
        S_FETCH: begin
          MemRd = 1'b1;
          if (mem_ready) begin
            IRWr = 1'b1;
            PCWr = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            nPC_sel = 1'b1;
            PCWr    = taken;
          end
        end
        S_MEM: begin
          IorD  = 1'b1;
          MemRd = (op_q == OP_LW);
          MemWr = (op_q == OP_SW);
        end
        S_WB: begin
          RegWr    = 1'b1;
          MemToReg = (op_q == OP_LW);
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = instr_count_q;

endmodule
